ldpc_encoder: RTL and testbench
===============================

Name: ldpc_encoder

Overview:
Systematic binary linear-block (LDPC) encoder.
- Takes K information bits and a runtime-loaded parity portion P (K x (N-K)) of the systematic generator matrix G = [I_K | P].
- Produces a registered N-bit codeword = [info | info·P] over GF(2).
- Sits at the head of the LDPC datapath, feeding the channel/decoder model.

Parameters:
N, 11, codeword length in bits (N > K >= 1)
K, 6, information length in bits

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
i_en  input  1  encode enable; samples inputs on the rising clk edge when high
info_bits  input  K  information word; bit i is info bit i
generator_p  input  K*(N-K)  P matrix, row-major; row i = generator_p[i*(N-K) +: N-K]; column j of row i = generator_p[i*(N-K)+j]
codeword  output  N  registered codeword
o_valid  output  1  high for the cycle(s) codeword holds a result from an enabled cycle

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - Asserting rst_n low immediately clears codeword to 0 and o_valid to 0, regardless of clk.
  - Deassertion takes effect at the next rising clk edge.
- Parity computation (combinational, GF(2)):
  - parity[j] = XOR over i=0..K-1 of (info_bits[i] AND generator_p[i*(N-K)+j]), for j = 0..N-K-1.
- Codeword layout (systematic):
  - codeword[N-1:N-K] = info_bits (info_bits[K-1] at codeword[N-1]).
  - codeword[N-K-1:0] = parity (parity[0] at codeword[0]).
- Latency and registering:
  - On a rising edge with rst_n=1 and i_en=1: codeword <= {info_bits, parity}; o_valid <= 1.
  - Latency is exactly 1 clock from the sampled inputs.
  - Throughput is one codeword per cycle while i_en stays high.
- i_en low: codeword holds its last value; o_valid <= 0.
- Changing generator_p or info_bits between edges has no effect on the outputs until the next enabled edge. There are no glitches on the outputs.
- Reset while i_en is high: reset wins; outputs stay 0 until the first enabled edge after release.
- No handshake and no backpressure; the consumer must capture codeword while o_valid=1.
- Width rules:
  - All arithmetic is XOR/AND; no carries.
  - generator_p width is exactly K*(N-K).
  - Out-of-range parameters (K >= N) are unsupported.
  - The elaboration check flags K >= N.

Decomposition:
- No shared package needed; N and K are plain parameters.
- Bit-index helper expressions (row offset i*(N-K)) are local.
- One natural sub-module: ldpc_parity_gen, a purely combinational block with the same N/K parameters.
  - Inputs: info_bits, generator_p. Output: parity[N-K-1:0].
  - Implemented as a generate loop of AND-XOR reduction trees.
- ldpc_encoder wraps ldpc_parity_gen with the output/valid registers and reset.

Test Plan:
- Reset: hold rst_n=0 with i_en=1 and info=6'b111111 -> codeword=11'b0 and o_valid=0, including mid-cycle assertion (asynchronous clear checked before the next edge).
- All-ones, default N=11/K=6: generator_p=30'b101001001010001011000101001001, info=6'b111111, i_en=1 -> one edge later codeword=11'b11111111000 (parity 5'b11000), o_valid=1.
- Single-row selection, same P:
  - info=6'b000001 -> codeword=11'b00000101001.
  - info=6'b100000 -> codeword=11'b10000010100.
- Two-row XOR, same P: info=6'b000011 -> codeword=11'b00001100011. Back-to-back with the previous vectors on consecutive edges, each result appears exactly one cycle after its input.
- Zero and hold: info=6'b000000 -> codeword=11'b0. Then set i_en=0 and change info to 6'b101010 -> codeword unchanged and o_valid=0. Re-enable -> codeword updates one edge later.
- Randomized: random P and info over 1000 cycles with random i_en -> compare against a GF(2) matrix-multiply reference model, including the hold behaviour when i_en=0.

Source files
------------

// File: rtl/ldpc_encoder_pkg.sv
// Default code dimensions for the systematic LDPC encoder.
// N and K remain plain module parameters; these only supply the defaults.
package ldpc_encoder_pkg;
    localparam int DEF_N = 11;
    localparam int DEF_K = 6;
endpackage

// File: rtl/ldpc_parity_gen.sv
// Combinational GF(2) parity generator: parity = info_bits * P.
// One AND-XOR reduction tree per parity column.
module ldpc_parity_gen
    import ldpc_encoder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic [K-1:0]       info_bits,
    input  logic [K*(N-K)-1:0] generator_p,
    output logic [N-K-1:0]     parity
);
    localparam int M = N - K;

    for (genvar j = 0; j < M; j++) begin : g_col
        logic [K-1:0] terms;
        // Column j picks bit j out of every row i, rows being M bits wide.
        for (genvar i = 0; i < K; i++) begin : g_row
            assign terms[i] = info_bits[i] & generator_p[i*M + j];
        end
        assign parity[j] = ^terms;
    end
endmodule

// File: rtl/ldpc_encoder.sv
// Systematic LDPC encoder: registers {info_bits, info_bits*P} with a valid flag.
// One-cycle latency, one codeword per enabled cycle, holds value when disabled.
module ldpc_encoder
    import ldpc_encoder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [K-1:0]       info_bits,
    input  logic [K*(N-K)-1:0] generator_p,
    output logic [N-1:0]       codeword,
    output logic               o_valid
);
    if (K >= N || K < 1) begin : g_param_check
        $error("ldpc_encoder: requires N > K >= 1");
    end

    logic [N-K-1:0] parity;

    ldpc_parity_gen #(
        .N(N),
        .K(K)
    ) u_parity_gen (
        .info_bits  (info_bits),
        .generator_p(generator_p),
        .parity     (parity)
    );

    // Output stage: codeword is cleared by reset as well as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codeword <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= i_en;
            if (i_en) begin
                codeword <= {info_bits, parity};
            end
        end
    end
endmodule

// File: tb/tb_ldpc_encoder.sv
// Self-checking bench for ldpc_encoder: directed vector table, reset sequences,
// and randomized traffic against a counting GF(2) matrix-multiply model.
module tb_ldpc_encoder;
    localparam int N = 11;
    localparam int K = 6;
    localparam int M = N - K;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_en;
    logic [K-1:0]     info_bits;
    logic [K*M-1:0]   generator_p;
    logic [N-1:0]     codeword;
    logic             o_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ldpc_encoder #(.N(N), .K(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .info_bits  (info_bits),
        .generator_p(generator_p),
        .codeword   (codeword),
        .o_valid    (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [K-1:0] info;
        logic [N-1:0] exp_cw;
        logic         exp_v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Parity bit j is the parity of the count of rows selected by info
    // that have a one in column j; info sits in the upper K bits.
    function automatic logic [N-1:0] ref_cw(input logic [K-1:0] info, input logic [K*M-1:0] p);
        logic [N-1:0] cw;
        cw = '0;
        for (int j = 0; j < M; j++) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < K; i++)
                if (info[i] == 1'b1 && p[i*M + j] == 1'b1) cnt++;
            cw[j] = (cnt % 2 == 1);
        end
        for (int i = 0; i < K; i++) cw[M + i] = info[i];
        return cw;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_cw;
    logic         exp_v;
    logic [N-1:0] held_cw;

    initial begin
        vecs[0] = '{1'b1, 6'b111111, 11'b11111111000, 1'b1};
        vecs[1] = '{1'b1, 6'b000001, 11'b00000101001, 1'b1};
        vecs[2] = '{1'b1, 6'b100000, 11'b10000010100, 1'b1};
        vecs[3] = '{1'b1, 6'b000011, 11'b00001100011, 1'b1};
        vecs[4] = '{1'b1, 6'b000000, 11'b00000000000, 1'b1};
        vecs[5] = '{1'b0, 6'b101010, 11'b00000000000, 1'b0};
        vecs[6] = '{1'b1, 6'b101010, 11'b10101001111, 1'b1};
        vecs[7] = '{1'b0, 6'b111111, 11'b10101001111, 1'b0};

        generator_p = 30'b101001001010001011000101001001;
        info_bits   = 6'b111111;
        i_en        = 1'b1;
        rst_n       = 1'b0;
        #1;
        check("reset_cw_async", 32'(codeword), 32'd0);
        check("reset_v_async", 32'(o_valid), 32'd0);
        step();
        step();
        check("reset_cw_held", 32'(codeword), 32'd0);
        check("reset_v_held", 32'(o_valid), 32'd0);

        rst_n = 1'b1;
        step();
        check("post_reset_cw", 32'(codeword), 32'b11111111000);
        check("post_reset_v", 32'(o_valid), 32'd1);

        // Asynchronous clear mid-cycle, checked before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("midcycle_reset_cw", 32'(codeword), 32'd0);
        check("midcycle_reset_v", 32'(o_valid), 32'd0);
        step();
        check("reset_wins_cw", 32'(codeword), 32'd0);
        check("reset_wins_v", 32'(o_valid), 32'd0);
        rst_n = 1'b1;

        // Directed table, back-to-back on consecutive edges.
        for (int t = 0; t < 8; t++) begin
            i_en      = vecs[t].en;
            info_bits = vecs[t].info;
            step();
            check($sformatf("vec%0d_cw", t), 32'(codeword), 32'(vecs[t].exp_cw));
            check($sformatf("vec%0d_v", t), 32'(o_valid), 32'(vecs[t].exp_v));
        end

        // Inputs changed between edges must not reach the output.
        held_cw     = codeword;
        info_bits   = 6'b010101;
        generator_p = ~generator_p;
        #2;
        check("between_edges_cw", 32'(codeword), 32'(held_cw));

        // Randomized traffic against the reference model.
        exp_cw = codeword;
        exp_v  = o_valid;
        for (int c = 0; c < 1000; c++) begin
            i_en        = ($urandom_range(0, 3) != 0);
            info_bits   = K'($urandom);
            generator_p = (K*M)'($urandom);
            if (i_en) begin
                exp_cw = ref_cw(info_bits, generator_p);
                exp_v  = 1'b1;
            end else begin
                exp_v  = 1'b0;
            end
            step();
            check("rand_cw", 32'(codeword), 32'(exp_cw));
            check("rand_v", 32'(o_valid), 32'(exp_v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
